echo_delay_line: RTL and testbench

//  Parametrised audio delay/echo between the mic sample path and the output path.

---
 rtl/sigdelay_pkg.sv | 30 +++
 rtl/delay_ram.sv | 23 ++
 rtl/echo_delay_line.sv | 138 +++++++++++++
 tb/tb_echo_delay_line.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigdelay_pkg.sv
// Shared types and helpers for the echo delay line: mode encoding, zero level, clamped add.
// Pure definitions, no latency or flow control of its own.
package sigdelay_pkg;

  typedef enum logic [1:0] {
    BYPASS = 2'b00,
    DELAY  = 2'b01,
    ECHO   = 2'b10,
    MUTE   = 2'b11
  } mode_t;

  // Offset-binary zero level for a sample of the given width.
  function automatic int mid(input int d_width);
    return 1 << (d_width - 1);
  endfunction

  // Signed sum clamped to the signed range of a d_width-bit sample.
  function automatic int sat_add(input int a, input int b, input int d_width);
    int sum;
    int hi;
    int lo;
    sum = a + b;
    hi  = mid(d_width) - 1;
    lo  = -mid(d_width);
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Sample buffer, one write port and one registered read port; read latency 1 cycle.
// No flow control; a read colliding with a write to the same word returns the old word.
module delay_ram #(
  parameter int A_WIDTH = 9,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [A_WIDTH-1:0] wr_addr,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic               rd_en,
  input  logic [A_WIDTH-1:0] rd_addr,
  output logic [D_WIDTH-1:0] rd_data
);

  logic [D_WIDTH-1:0] mem [2**A_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/echo_delay_line.sv
// Circular-buffer delay/echo on an offset-binary sample stream, modes bypass/delay/echo/mute.
// Result appears 2 cycles after the accepting in_valid; no backpressure, one sample per cycle max.
module echo_delay_line #(
  parameter int A_WIDTH = 9,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [D_WIDTH-1:0] in_sample,
  input  logic [A_WIDTH-1:0] delay,
  input  logic [1:0]         mode,
  input  logic [2:0]         fb_shift,
  output logic               out_valid,
  output logic [D_WIDTH-1:0] out_sample,
  output logic               primed
);
  import sigdelay_pkg::*;

  localparam int                 MID_I    = mid(D_WIDTH);
  localparam logic [D_WIDTH-1:0] MID      = {1'b1, {(D_WIDTH-1){1'b0}}};
  localparam logic [A_WIDTH-1:0] FILL_MAX = '1;

  typedef struct packed {
    logic [D_WIDTH-1:0] smp;
    mode_t              mode;
    logic [2:0]         fb_shift;
    logic [A_WIDTH-1:0] wp;
    logic               tap_ok;
    logic               fwd_hit;
    logic [D_WIDTH-1:0] fwd_dat;
  } s1_t;

  logic [A_WIDTH-1:0] wr_ptr;
  logic [A_WIDTH-1:0] fill;
  logic               s1_vld;
  s1_t                s1;

  logic [A_WIDTH-1:0] wp_eff;
  logic [A_WIDTH-1:0] fill_eff;
  logic [A_WIDTH-1:0] fill_nxt;
  logic [A_WIDTH-1:0] rd_addr;
  logic               tap_ok;
  logic               fwd_hit;

  logic [D_WIDTH-1:0] ram_q;
  logic [D_WIDTH-1:0] d;
  logic [D_WIDTH-1:0] y;
  logic [D_WIDTH-1:0] out_d;
  logic [D_WIDTH-1:0] wr_d;
  int                 s_i;
  int                 e_i;
  int                 y_i;

  // Accept stage: a clr arriving with a sample makes that sample the first one in the buffer.
  always_comb begin
    wp_eff   = clr ? '0 : wr_ptr;
    fill_eff = clr ? '0 : fill;
    rd_addr  = wp_eff - delay;
    tap_ok   = (fill_eff >= delay) && (delay != '0);
    fill_nxt = (fill_eff == FILL_MAX) ? fill_eff : fill_eff + A_WIDTH'(1);
    // The word written by the sample now in S1 is not yet visible to this read.
    fwd_hit  = s1_vld && (s1.wp == rd_addr);
  end

  always_comb begin
    if (!s1.tap_ok)
      d = MID;
    else if (s1.fwd_hit)
      d = s1.fwd_dat;
    else
      d = ram_q;

    s_i = int'(s1.smp) - MID_I;
    e_i = int'(d) - MID_I;
    y_i = sat_add(s_i, e_i >>> s1.fb_shift, D_WIDTH) + MID_I;
    y   = D_WIDTH'(y_i);

    out_d = s1.smp;
    wr_d  = s1.smp;
    case (s1.mode)
      BYPASS: out_d = s1.smp;
      DELAY:  out_d = d;
      ECHO: begin
        out_d = y;
        wr_d  = y;
      end
      default: out_d = MID;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      fill       <= '0;
      s1_vld     <= 1'b0;
      s1         <= '0;
      out_valid  <= 1'b0;
      out_sample <= MID;
    end else begin
      s1_vld    <= in_valid;
      out_valid <= s1_vld;
      if (s1_vld) out_sample <= out_d;

      if (in_valid) begin
        s1 <= '{smp:      in_sample,
                mode:     mode_t'(mode),
                fb_shift: fb_shift,
                wp:       wp_eff,
                tap_ok:   tap_ok,
                fwd_hit:  fwd_hit,
                fwd_dat:  wr_d};
        wr_ptr <= wp_eff + A_WIDTH'(1);
        fill   <= fill_nxt;
      end else if (clr) begin
        wr_ptr <= '0;
        fill   <= '0;
      end
    end
  end

  assign primed = (fill >= delay);

  delay_ram #(
    .A_WIDTH(A_WIDTH),
    .D_WIDTH(D_WIDTH)
  ) u_ram (
    .clk    (clk),
    .wr_en  (s1_vld),
    .wr_addr(s1.wp),
    .wr_data(wr_d),
    .rd_en  (in_valid),
    .rd_addr(rd_addr),
    .rd_data(ram_q)
  );

endmodule

// File: tb/tb_echo_delay_line.sv
// Scoreboard bench for echo_delay_line: expected samples queued at drive time, checked on out_valid.
module tb_echo_delay_line;
  import sigdelay_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_sample = 8'd0;
  logic [8:0] delay = 9'd0;
  logic [1:0] mode = 2'd0;
  logic [2:0] fb_shift = 3'd0;
  logic       out_valid;
  logic [7:0] out_sample;
  logic       primed;

  echo_delay_line #(.A_WIDTH(9), .D_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_sample (in_sample),
    .delay     (delay),
    .mode      (mode),
    .fb_shift  (fb_shift),
    .out_valid (out_valid),
    .out_sample(out_sample),
    .primed    (primed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] val;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] held = 8'd128;

  // Behavioural reference: plain circular buffer, one sample at a time.
  logic [7:0] m_mem [512];
  int         m_wp = 0;
  int         m_fill = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held = 8'd128;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out_valid cycle %0d got %0d required no pulse", cyc, out_sample);
        held = out_sample;
      end else begin
        e = sb.pop_front();
        tests++;
        if (out_sample !== e.val) begin
          fails++;
          $display("FAIL out_sample cycle %0d got %0d required %0d", cyc, out_sample, e.val);
        end
        tests++;
        if (cyc !== e.cyc) begin
          fails++;
          $display("FAIL latency got cycle %0d required cycle %0d", cyc, e.cyc);
        end
        held = e.val;
      end
    end else begin
      tests++;
      if (out_sample !== held) begin
        fails++;
        $display("FAIL hold cycle %0d got %0d required %0d", cyc, out_sample, held);
      end
    end
  end

  task automatic model_step(input logic [7:0] smp, input logic [8:0] dly, input mode_t md,
                            input logic [2:0] fb, input logic with_clr, output logic [7:0] res);
    int d;
    int s;
    int e;
    int y;
    logic [7:0] w;
    if (with_clr) begin
      m_wp   = 0;
      m_fill = 0;
    end
    if (dly != 9'd0 && m_fill >= int'(dly))
      d = int'(m_mem[9'(m_wp - int'(dly))]);
    else
      d = 128;
    s = int'(smp) - 128;
    e = d - 128;
    y = s + (e >>> fb);
    if (y > 127) y = 127;
    if (y < -128) y = -128;
    y = y + 128;
    case (md)
      BYPASS:  begin res = smp;     w = smp;   end
      DELAY:   begin res = 8'(d);   w = smp;   end
      ECHO:    begin res = 8'(y);   w = 8'(y); end
      default: begin res = 8'd128;  w = smp;   end
    endcase
    m_mem[9'(m_wp)] = w;
    m_wp = (m_wp + 1) & 511;
    if (m_fill < 511) m_fill++;
  endtask

  // lit >= 0 pushes that literal as the expectation instead of the model result.
  task automatic send(input logic [7:0] smp, input logic [8:0] dly, input mode_t md,
                      input logic [2:0] fb, input logic with_clr, input int lit);
    exp_t       e;
    logic [7:0] mv;
    model_step(smp, dly, md, fb, with_clr, mv);
    e.val = (lit >= 0) ? 8'(lit) : mv;
    e.cyc = cyc + 2;
    sb.push_back(e);
    in_sample = smp;
    delay     = dly;
    mode      = md;
    fb_shift  = fb;
    clr       = with_clr;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clr();
    m_wp   = 0;
    m_fill = 0;
    clr    = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s_drain got %0d pending required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    delay = 9'd0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b required 0", out_valid); end
    tests++;
    if (out_sample !== 8'd128) begin fails++; $display("FAIL reset_out_sample got %0d required 128", out_sample); end
    tests++;
    if (primed !== 1'b1) begin fails++; $display("FAIL reset_primed_d0 got %0b required 1", primed); end
    delay = 9'd4;
    #1;
    tests++;
    if (primed !== 1'b0) begin fails++; $display("FAIL reset_primed_d4 got %0b required 0", primed); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_delay4();
    do_clr();
    for (int k = 0; k < 10; k++)
      send(8'(k + 1), 9'd4, DELAY, 3'd0, 1'b0, (k < 4) ? 128 : k - 3);
    drain("delay4");
    tests++;
    if (primed !== 1'b1) begin fails++; $display("FAIL delay4_primed got %0b required 1", primed); end
  endtask

  task automatic test_bypass_delay0();
    do_clr();
    for (int k = 0; k <= 20; k++) send(8'(k), 9'd0, BYPASS, 3'd0, 1'b0, k);
    for (int k = 0; k <= 20; k++) send(8'(k), 9'd0, DELAY, 3'd0, 1'b0, 128);
    drain("bypass_delay0");
    tests++;
    if (primed !== 1'b1) begin fails++; $display("FAIL delay0_primed got %0b required 1", primed); end
  endtask

  task automatic test_wrap();
    do_clr();
    for (int k = 0; k < 1200; k++)
      send(8'(k), 9'd511, DELAY, 3'd0, 1'b0, (k >= 511) ? (k - 511) % 256 : 128);
    drain("wrap");
  endtask

  task automatic test_echo();
    int lits[8] = '{192, 160, 144, 136, 132, 130, 129, 128};
    do_clr();
    for (int k = 0; k < 8; k++)
      send((k == 0) ? 8'd192 : 8'd128, 9'd1, ECHO, 3'd1, 1'b0, lits[k]);
    for (int k = 0; k < 6; k++) send(8'd255, 9'd1, ECHO, 3'd0, 1'b0, 255);
    drain("echo");
  endtask

  task automatic test_gapped();
    do_clr();
    for (int k = 0; k < 12; k++) begin
      send(8'(200 + k), 9'd2, DELAY, 3'd0, 1'b0, (k < 2) ? 128 : 198 + k);
      idle(2);
    end
    drain("gapped");
  endtask

  task automatic test_clr();
    do_clr();
    for (int k = 0; k < 20; k++)
      send(8'(50 + k), 9'd4, DELAY, 3'd0, 1'b0, (k < 4) ? 128 : 46 + k);
    do_clr();
    tests++;
    if (primed !== 1'b0) begin fails++; $display("FAIL clr_primed got %0b required 0", primed); end
    for (int k = 0; k < 6; k++) begin
      send(8'(100 + k), 9'd4, DELAY, 3'd0, 1'b0, (k < 4) ? 128 : 96 + k);
      tests++;
      if (primed !== ((k >= 3) ? 1'b1 : 1'b0)) begin
        fails++;
        $display("FAIL clr_refill_primed_%0d got %0b required %0b", k, primed, (k >= 3));
      end
    end
    send(8'd77, 9'd1, DELAY, 3'd0, 1'b1, 128);
    tests++;
    if (primed !== 1'b1) begin fails++; $display("FAIL clr_with_valid_primed got %0b required 1", primed); end
    send(8'd88, 9'd1, DELAY, 3'd0, 1'b0, 77);
    drain("clr");
  endtask

  task automatic test_rst_mid();
    do_clr();
    for (int k = 0; k < 5; k++)
      send(8'(30 + k), 9'd2, DELAY, 3'd0, 1'b0, (k < 2) ? 128 : 28 + k);
    #1;
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_out_valid got %0b required 0", out_valid); end
    tests++;
    if (out_sample !== 8'd128) begin fails++; $display("FAIL rst_mid_out_sample got %0d required 128", out_sample); end
    tests++;
    if (primed !== 1'b0) begin fails++; $display("FAIL rst_mid_primed got %0b required 0", primed); end
    sb.delete();
    m_wp   = 0;
    m_fill = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(6);
  endtask

  initial begin
    test_reset();
    test_delay4();
    test_bypass_delay0();
    test_wrap();
    test_echo();
    test_gapped();
    test_clr();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
